// File: rtl/jtag_dr_sequencer_if.sv
// Command, serial data-register and response signals of the JTAG DR sequencer.
// The master modport is the sequencer; slave is the requester/responder side.
interface jtag_dr_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              tdi;
  logic              ir_in;
  logic              v_sdr;
  logic              udr;
  logic              tdo;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, tdo,
    output cmd_ready, tdi, ir_in, v_sdr, udr, rsp_valid, rsp_rdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, tdo,
    input  cmd_ready, tdi, ir_in, v_sdr, udr, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/jtag_dr_sequencer.sv
// Serializes parallel write/read commands onto virtual-JTAG DR strobes (tdi/ir_in/v_sdr/udr).
// Define JTAG_SEQ_READBACK_EN to build the read path (tdo capture and response).
module jtag_dr_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input logic                 clk,
  input logic                 aclr,
  jtag_dr_sequencer_if.master bus
);

  localparam int unsigned MaxW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned CntW = $clog2(MaxW) + 1;

  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StShData,
    StUpdData,
    StShAddr,
    StUpdAddr
`ifdef JTAG_SEQ_READBACK_EN
    ,
    StRdWait,
    StShRd,
    StResp
`endif
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] dsr_q;
  logic [ADDR_W-1:0] asr_q;
  logic              cmd_ready_q;
  logic              tdi_q;
  logic              ir_in_q;
  logic              v_sdr_q;
  logic              udr_q;

`ifdef JTAG_SEQ_READBACK_EN
  localparam bit SkipWait = (RD_LAT == 0);

  logic              rd_q;
  logic [DATA_W-1:0] cap_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] cap_next;

  // LSB-first capture: each new tdo bit enters at the top and drifts down.
  assign cap_next = {bus.tdo, cap_q[DATA_W-1:1]};
`endif

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dsr_q       <= '0;
      asr_q       <= '0;
      cmd_ready_q <= 1'b1;
      tdi_q       <= 1'b0;
      ir_in_q     <= 1'b0;
      v_sdr_q     <= 1'b0;
      udr_q       <= 1'b0;
`ifdef JTAG_SEQ_READBACK_EN
      rd_q        <= 1'b0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            v_sdr_q     <= 1'b1;
            cnt_q       <= '0;
`ifdef JTAG_SEQ_READBACK_EN
            rd_q        <= !bus.cmd_write;
            if (!bus.cmd_write) begin
              // Reads skip the data register and go straight to the address shift.
              state_q <= StShAddr;
              ir_in_q <= 1'b0;
              tdi_q   <= bus.cmd_addr[0];
              asr_q   <= bus.cmd_addr >> 1;
            end else
`endif
            begin
              state_q <= StShData;
              ir_in_q <= 1'b1;
              tdi_q   <= bus.cmd_wdata[0];
              dsr_q   <= bus.cmd_wdata >> 1;
              asr_q   <= bus.cmd_addr;
            end
          end
        end

        StShData: begin
          if (cnt_q == DataLast) begin
            state_q <= StUpdData;
            cnt_q   <= '0;
            tdi_q   <= 1'b0;
            v_sdr_q <= 1'b0;
            udr_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
            tdi_q   <= dsr_q[0];
            dsr_q   <= dsr_q >> 1;
          end
        end

        StUpdData: begin
          state_q <= StShAddr;
          cnt_q   <= '0;
          udr_q   <= 1'b0;
          ir_in_q <= 1'b0;
          v_sdr_q <= 1'b1;
          tdi_q   <= asr_q[0];
          asr_q   <= asr_q >> 1;
        end

        StShAddr: begin
          if (cnt_q == AddrLast) begin
            state_q <= StUpdAddr;
            cnt_q   <= '0;
            tdi_q   <= 1'b0;
            v_sdr_q <= 1'b0;
            udr_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
            tdi_q   <= asr_q[0];
            asr_q   <= asr_q >> 1;
          end
        end

        StUpdAddr: begin
          udr_q <= 1'b0;
          cnt_q <= '0;
`ifdef JTAG_SEQ_READBACK_EN
          if (rd_q) begin
            ir_in_q <= 1'b1;
            if (SkipWait) begin
              state_q <= StShRd;
              v_sdr_q <= 1'b1;
            end else begin
              state_q <= StRdWait;
            end
          end else
`endif
          begin
            state_q     <= StIdle;
            ir_in_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

`ifdef JTAG_SEQ_READBACK_EN
        StRdWait: begin
          if (cnt_q == WaitLast) begin
            state_q <= StShRd;
            cnt_q   <= '0;
            v_sdr_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
          end
        end

        StShRd: begin
          cap_q <= cap_next;
          if (cnt_q == DataLast) begin
            state_q     <= StResp;
            cnt_q       <= '0;
            v_sdr_q     <= 1'b0;
            ir_in_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= cap_next;
          end else begin
            cnt_q       <= cnt_q + CntW'(1);
          end
        end

        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
`endif

        default: begin
          state_q     <= StIdle;
          cnt_q       <= '0;
          cmd_ready_q <= 1'b1;
          tdi_q       <= 1'b0;
          ir_in_q     <= 1'b0;
          v_sdr_q     <= 1'b0;
          udr_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.tdi       = tdi_q;
  assign bus.ir_in     = ir_in_q;
  assign bus.v_sdr     = v_sdr_q;
  assign bus.udr       = udr_q;

`ifdef JTAG_SEQ_READBACK_EN
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`else
  // Write-only build: the read-side inputs and wait length have no consumer.
  logic unused_in;
  assign unused_in     = ^{bus.tdo, bus.cmd_write, WaitLast};
  assign bus.rsp_valid = 1'b0;
  assign bus.rsp_rdata = '0;
`endif

endmodule

// File: doc/jtag_dr_sequencer.md
# jtag_dr_sequencer

- On-chip initiator for the virtual-JTAG data-register interface.
- Takes parallel write/read commands (address, data) from a local requester and serializes them onto the same `tdi`/`ir_in`/`v_sdr`/`udr` strobes that the SRAM-bridge responder consumes. On reads it captures `tdo` back into a parallel word.
- Sits between a local command source (self-test, scripted loader) and the JTAG-side responder, so the responder can be driven from RTL instead of a bench.

## Interface

Parameters:
- `DATA_W`, 8: bits shifted into DR1 (data register).
- `ADDR_W`, 8: bits shifted into DR2 (address register).
- `RD_LAT`, 2: idle cycles between the address update and the DR1 read shift, for SRAM access.

Ports:
- `clk`  in  1: single clock. All shifting happens at one bit per `clk`.
- `aclr`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: block idle and able to accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  `ADDR_W`: target address.
- `cmd_wdata`  in  `DATA_W`: write data. Ignored on reads.
- `tdi`  out  1: serial data to the responder, LSB first.
- `ir_in`  out  1: register select. 1 = DR1 (data), 0 = DR2 (address).
- `v_sdr`  out  1: shift-DR qualifier. High exactly on valid bit cycles.
- `udr`  out  1: update-DR strobe, one-cycle pulse.
- `tdo`  in  1: serial data from the responder.
- `rsp_valid`  out  1: one-cycle pulse when read data is valid.
- `rsp_rdata`  out  `DATA_W`: captured read data. Held until the next read completes.

## Operation

- The command is accepted on a `clk` edge where `cmd_valid && cmd_ready`. Address, data and type are latched into internal shift/command registers.
- States: IDLE, SH_DATA, UPD_DATA, SH_ADDR, UPD_ADDR, RD_WAIT, SH_RD, RESP.
- Write path: IDLE → SH_DATA (`DATA_W` cycles) → UPD_DATA (1) → SH_ADDR (`ADDR_W`) → UPD_ADDR (1) → IDLE.
- Read path: IDLE → SH_ADDR (`ADDR_W`) → UPD_ADDR (1) → RD_WAIT (`RD_LAT`; 0 skips the state) → SH_RD (`DATA_W`) → RESP (1) → IDLE.
- SH_DATA:
  - `ir_in`=1, `v_sdr`=1.
  - `tdi` = `cmd_wdata[k]` on the k-th shift cycle, k=0..`DATA_W`-1.
- SH_ADDR:
  - `ir_in`=0, `v_sdr`=1.
  - `tdi` = `cmd_addr[k]` on the k-th shift cycle, k=0..`ADDR_W`-1.
- UPD_DATA / UPD_ADDR:
  - `udr`=1, `v_sdr`=0.
  - `ir_in` holds the value of the preceding shift state.
  - `tdi`=0.
- RD_WAIT:
  - `ir_in`=1; `v_sdr`, `udr` and `tdi` are 0.
- SH_RD:
  - `ir_in`=1, `v_sdr`=1, `tdi`=0.
  - On each cycle, `tdo` is sampled into bit k of the capture register, LSB first.
- RESP:
  - `rsp_valid`=1 and `rsp_rdata` = capture register.
- IDLE:
  - `cmd_ready`=1.
  - `tdi`, `ir_in`, `v_sdr`, `udr` and `rsp_valid` are all 0.
- Bit counter:
  - Width is clog2(max(`DATA_W`,`ADDR_W`))+1.
  - Cleared on every state entry.
  - A state exits when count == length−1.
- `cmd_valid` while `cmd_ready`=0 is ignored. The requester must hold it.

## Timing

- All outputs are registered.
- Reset value of every output is 0, except `cmd_ready`=1.
- Write command accepted at edge 0:
  - First data bit appears on `tdi`/`v_sdr` in cycle 1.
  - `udr` pulses in cycle `DATA_W`+1 and again in cycle `DATA_W`+`ADDR_W`+2.
  - `cmd_ready` returns high in cycle `DATA_W`+`ADDR_W`+3.
- Read command accepted at edge 0:
  - `udr` pulses in cycle `ADDR_W`+1.
  - `tdo` is captured in cycles `ADDR_W`+`RD_LAT`+2 .. `ADDR_W`+`RD_LAT`+`DATA_W`+1.
  - `rsp_valid` pulses in the following cycle; `cmd_ready` is high the cycle after that.
- Back-to-back commands: a new command can be accepted on the first IDLE cycle. There is no mandatory gap beyond one IDLE cycle.
- `aclr` mid-operation:
  - All outputs return to reset values immediately.
  - The partial shift is discarded, no `udr` is issued, and no `rsp_valid` is produced.
  - `rsp_rdata` is cleared to 0.

## Configuration

- `JTAG_SEQ_READBACK_EN` defined: read path present (RD_WAIT, SH_RD, RESP states, `tdo` capture, response ports active).
- Undefined:
  - `cmd_write` is ignored and every command is a write.
  - `tdo` is unused.
  - `rsp_valid` and `rsp_rdata` are tied to 0.
  - The three read states are not synthesized.

## Test plan

- Write `cmd_addr`=0x10, `cmd_wdata`=0xAA:
  - `tdi` during the `ir_in`=1 shift is 0,1,0,1,0,1,0,1; `udr` pulses in cycle 9.
  - `tdi` during the `ir_in`=0 shift is 0,0,0,0,1,0,0,0; `udr` pulses in cycle 18.
  - `cmd_ready` is high in cycle 19.
- Read `cmd_addr`=0x10, with the responder model returning 0xAA serially on `tdo`:
  - Address shift and `udr` in cycle 9; `rsp_valid` in cycle 20; `rsp_rdata`=0xAA.
- Back-to-back writes of (0x01,0x55) then (0x02,0x33) with `cmd_valid` held:
  - The second is accepted on the first IDLE cycle.
  - Four `udr` pulses total, with no overlap.
- Assert `aclr` during cycle 4 of SH_DATA:
  - All outputs are 0 on the same cycle and `cmd_ready`=1 after release.
  - No `udr` is observed.
- Pulse `cmd_valid` with a different command while busy: the command is ignored, and the in-flight sequence bits are unchanged.
- With `JTAG_SEQ_READBACK_EN` undefined, issue a read command: it executes as a write sequence, and `rsp_valid` stays 0.
